// File: rtl/pc_fetch_gen.sv
// Program-counter and instruction-fetch sequencer: single-outstanding imem handshake,
// prioritised redirects with kill of in-flight fetches, and misaligned-target trapping.
module pc_fetch_gen #(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int unsigned     INCR         = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            branch_jal,
  input  logic [XLEN-1:0] branch_jump_address,
  input  logic            jalr,
  input  logic [XLEN-1:0] jalr_address,
  input  logic            trap,
  input  logic [XLEN-1:0] trap_vector,
  input  logic            mret,
  input  logic [XLEN-1:0] mepc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_valid,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst_pc,
  output logic [XLEN-1:0] pc_out,
  output logic            misaligned_fault,
  output logic [XLEN-1:0] fault_addr
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            outstanding_q, outstanding_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            misaligned_fault_q, misaligned_fault_d;
  logic [XLEN-1:0] fault_addr_q, fault_addr_d;

  logic [XLEN-1:0] target;
  logic            target_misaligned;
  logic            redirect_now;
  logic            accept;
  logic            resp;

  // Priority select of the redirect target and its alignment check.
  always_comb begin
    target            = '0;
    target_misaligned = 1'b0;
    if (trap) begin
      target            = {trap_vector[XLEN-1:2], 2'b00};
      target_misaligned = 1'b0;
    end else if (mret) begin
      target            = mepc;
      target_misaligned = |mepc[1:0];
    end else if (branch_jal) begin
      target            = branch_jump_address;
      target_misaligned = |branch_jump_address[1:0];
    end else if (jalr) begin
      target            = {jalr_address[XLEN-1:1], 1'b0};
      target_misaligned = jalr_address[1];
    end
  end

  // BOOT ignores every redirect; FAULT only listens to trap.
  always_comb begin
    redirect_now = 1'b0;
    case (state_q)
      ST_RUN:   redirect_now = trap | mret | branch_jal | jalr;
      ST_FAULT: redirect_now = trap;
      default:  redirect_now = 1'b0;
    endcase
  end

  assign imem_req  = (state_q == ST_RUN) && !stall && !outstanding_q;
  assign imem_addr = pc_q;
  assign pc_out    = pc_q;
  assign accept    = imem_req && imem_ready;
  assign resp      = imem_valid && outstanding_q;

  assign inst_valid       = resp && !kill_q && !redirect_now;
  assign inst_pc          = inflight_pc_q;
  assign misaligned_fault = misaligned_fault_q;
  assign fault_addr       = fault_addr_q;

  // Next-state and datapath update.
  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    outstanding_d      = outstanding_q;
    kill_d             = kill_q;
    inflight_pc_d      = inflight_pc_q;
    misaligned_fault_d = 1'b0;
    fault_addr_d       = fault_addr_q;

    case (state_q)
      ST_BOOT:  state_d = ST_RUN;
      ST_RUN:   if (redirect_now && target_misaligned) state_d = ST_FAULT;
      ST_FAULT: if (redirect_now) state_d = ST_RUN;
      default:  state_d = ST_BOOT;
    endcase

    if (accept) begin
      inflight_pc_d = pc_q;
      outstanding_d = 1'b1;
      kill_d        = 1'b0;
      pc_d          = pc_q + XLEN'(INCR);
    end else if (resp) begin
      outstanding_d = 1'b0;
    end

    if (redirect_now) begin
      // Anything still in flight after this cycle belongs to the old stream.
      if ((outstanding_q && !resp) || accept) kill_d = 1'b1;
      if (target_misaligned) begin
        pc_d               = pc_q;
        misaligned_fault_d = 1'b1;
        fault_addr_d       = target;
      end else begin
        pc_d = target;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q            <= ST_BOOT;
      pc_q               <= RESET_VECTOR;
      outstanding_q      <= 1'b0;
      kill_q             <= 1'b0;
      inflight_pc_q      <= RESET_VECTOR;
      misaligned_fault_q <= 1'b0;
      fault_addr_q       <= '0;
    end else begin
      state_q            <= state_d;
      pc_q               <= pc_d;
      outstanding_q      <= outstanding_d;
      kill_q             <= kill_d;
      inflight_pc_q      <= inflight_pc_d;
      misaligned_fault_q <= misaligned_fault_d;
      fault_addr_q       <= fault_addr_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Directed bench for pc_fetch_gen: sequential fetch, stall, kill, priority, faults, wrap, reset.
module tb_pc_fetch_gen;

  localparam int unsigned XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic            branch_jal;
  logic [XLEN-1:0] branch_jump_address;
  logic            jalr;
  logic [XLEN-1:0] jalr_address;
  logic            trap;
  logic [XLEN-1:0] trap_vector;
  logic            mret;
  logic [XLEN-1:0] mepc;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_valid;
  logic            inst_valid;
  logic [XLEN-1:0] inst_pc;
  logic [XLEN-1:0] pc_out;
  logic            misaligned_fault;
  logic [XLEN-1:0] fault_addr;

  int n_cmp = 0;
  int n_err = 0;

  pc_fetch_gen #(.XLEN(XLEN), .RESET_VECTOR(32'h100), .INCR(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .branch_jal(branch_jal), .branch_jump_address(branch_jump_address),
    .jalr(jalr), .jalr_address(jalr_address),
    .trap(trap), .trap_vector(trap_vector),
    .mret(mret), .mepc(mepc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_valid(imem_valid),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .pc_out(pc_out),
    .misaligned_fault(misaligned_fault), .fault_addr(fault_addr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; branch_jal = 0; branch_jump_address = '0;
    jalr = 0; jalr_address = '0; trap = 0; trap_vector = '0;
    mret = 0; mepc = '0; imem_ready = 0; imem_valid = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    clear_inputs();
    tick();
    rst = 1;
    tick();
  endtask

  task automatic test_reset();
    rst = 0;
    clear_inputs();
    imem_valid = 1;
    tick(); tick();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%0b want=0", imem_req); end
    n_cmp++; if (pc_out !== 32'h100) begin n_err++; $display("FAIL reset_pc got=%h want=00000100", pc_out); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_inst_valid got=%0b want=0", inst_valid); end
    n_cmp++; if (misaligned_fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%0b want=0", misaligned_fault); end
    n_cmp++; if (fault_addr !== 32'h0) begin n_err++; $display("FAIL reset_fault_addr got=%h want=0", fault_addr); end
    n_cmp++; if (inst_pc !== 32'h100) begin n_err++; $display("FAIL reset_inst_pc got=%h want=00000100", inst_pc); end
    rst = 1; imem_valid = 0; imem_ready = 1;
    branch_jal = 1; branch_jump_address = 32'h200;
    settle();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL boot_req got=%0b want=0", imem_req); end
    tick();
    branch_jal = 0;
    settle();
    n_cmp++; if (pc_out !== 32'h100) begin n_err++; $display("FAIL boot_ignores_redirect got=%h want=00000100", pc_out); end
    n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL run_req got=%0b want=1", imem_req); end
    n_cmp++; if (imem_addr !== 32'h100) begin n_err++; $display("FAIL run_addr got=%h want=00000100", imem_addr); end
  endtask

  task automatic test_sequential();
    logic [XLEN-1:0] exp;
    do_reset();
    imem_ready = 1;
    for (int i = 0; i < 3; i++) begin
      exp = 32'h100 + XLEN'(4 * i);
      settle();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== exp) begin n_err++; $display("FAIL seq_req req=%0b addr=%h want req=1 addr=%h", imem_req, imem_addr, exp); end
      tick();
      imem_valid = 1;
      settle();
      n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== exp) begin n_err++; $display("FAIL seq_resp valid=%0b pc=%h want valid=1 pc=%h", inst_valid, inst_pc, exp); end
      n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL seq_single_outstanding got=%0b want=0", imem_req); end
      tick();
      imem_valid = 0;
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_ready = 1;
    tick();
    stall = 1; imem_valid = 1;
    settle();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h100) begin n_err++; $display("FAIL stall_resp valid=%0b pc=%h want valid=1 pc=00000100", inst_valid, inst_pc); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL stall_req0 got=%0b want=0", imem_req); end
    tick();
    imem_valid = 0;
    for (int k = 0; k < 2; k++) begin
      settle();
      n_cmp++; if (imem_req !== 1'b0 || pc_out !== 32'h104) begin n_err++; $display("FAIL stall_hold req=%0b pc=%h want req=0 pc=00000104", imem_req, pc_out); end
      tick();
    end
    stall = 0;
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin n_err++; $display("FAIL stall_resume req=%0b addr=%h want req=1 addr=00000104", imem_req, imem_addr); end
    tick();
    imem_valid = 1;
    settle();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h104) begin n_err++; $display("FAIL stall_resume_resp valid=%0b pc=%h want valid=1 pc=00000104", inst_valid, inst_pc); end
    tick();
    imem_valid = 0;
  endtask

  task automatic test_branch_kill();
    do_reset();
    imem_ready = 1;
    tick();
    imem_valid = 1;
    tick();
    imem_valid = 0;
    tick();
    branch_jal = 1; branch_jump_address = 32'h200;
    settle();
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL kill_outstanding_req got=%0b want=0", imem_req); end
    tick();
    branch_jal = 0; imem_valid = 1;
    settle();
    n_cmp++; if (inst_valid !== 1'b0 || inst_pc !== 32'h104) begin n_err++; $display("FAIL kill_resp valid=%0b pc=%h want valid=0 pc=00000104", inst_valid, inst_pc); end
    n_cmp++; if (pc_out !== 32'h200) begin n_err++; $display("FAIL kill_pc got=%h want=00000200", pc_out); end
    tick();
    imem_valid = 0;
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin n_err++; $display("FAIL kill_next_req req=%0b addr=%h want req=1 addr=00000200", imem_req, imem_addr); end
    tick();
    imem_valid = 1;
    settle();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h200) begin n_err++; $display("FAIL kill_cleared valid=%0b pc=%h want valid=1 pc=00000200", inst_valid, inst_pc); end
    tick();
    imem_valid = 0;
  endtask

  task automatic test_redirect_on_accept();
    do_reset();
    imem_ready = 1;
    branch_jal = 1; branch_jump_address = 32'h40;
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL acc_redir_req req=%0b addr=%h want req=1 addr=00000100", imem_req, imem_addr); end
    tick();
    branch_jal = 0; imem_valid = 1;
    settle();
    n_cmp++; if (inst_valid !== 1'b0 || inst_pc !== 32'h100) begin n_err++; $display("FAIL acc_redir_kill valid=%0b pc=%h want valid=0 pc=00000100", inst_valid, inst_pc); end
    n_cmp++; if (pc_out !== 32'h40) begin n_err++; $display("FAIL acc_redir_pc got=%h want=00000040", pc_out); end
    tick();
    imem_valid = 0;
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_err++; $display("FAIL acc_redir_next req=%0b addr=%h want req=1 addr=00000040", imem_req, imem_addr); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    imem_ready = 1;
    tick();
    imem_valid = 1; branch_jal = 1; branch_jump_address = 32'h280;
    settle();
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL b2b_same_cycle_kill got=%0b want=0", inst_valid); end
    tick();
    imem_valid = 0; branch_jal = 0;
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h280) begin n_err++; $display("FAIL b2b_next_req req=%0b addr=%h want req=1 addr=00000280", imem_req, imem_addr); end
    tick();
    imem_valid = 1;
    settle();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h280) begin n_err++; $display("FAIL b2b_resp valid=%0b pc=%h want valid=1 pc=00000280", inst_valid, inst_pc); end
    tick();
    imem_valid = 0;
  endtask

  task automatic test_priority();
    do_reset();
    trap = 1; trap_vector = 32'h80; branch_jal = 1; branch_jump_address = 32'h300;
    tick();
    clear_inputs();
    settle();
    n_cmp++; if (pc_out !== 32'h80) begin n_err++; $display("FAIL prio_trap_over_branch got=%h want=00000080", pc_out); end
    mret = 1; mepc = 32'h500; branch_jal = 1; branch_jump_address = 32'h600; jalr = 1; jalr_address = 32'h700;
    tick();
    clear_inputs();
    settle();
    n_cmp++; if (pc_out !== 32'h500) begin n_err++; $display("FAIL prio_mret got=%h want=00000500", pc_out); end
    trap = 1; trap_vector = 32'h8B; branch_jal = 1; branch_jump_address = 32'h302;
    tick();
    clear_inputs();
    settle();
    n_cmp++; if (pc_out !== 32'h88) begin n_err++; $display("FAIL prio_trap_align got=%h want=00000088", pc_out); end
    n_cmp++; if (misaligned_fault !== 1'b0 || imem_req !== 1'b1) begin n_err++; $display("FAIL prio_no_fault fault=%0b req=%0b want fault=0 req=1", misaligned_fault, imem_req); end
    branch_jal = 1; branch_jump_address = 32'h900; jalr = 1; jalr_address = 32'hA00;
    tick();
    clear_inputs();
    settle();
    n_cmp++; if (pc_out !== 32'h900) begin n_err++; $display("FAIL prio_branch_over_jalr got=%h want=00000900", pc_out); end
  endtask

  task automatic test_jalr_fault();
    do_reset();
    jalr = 1; jalr_address = 32'h301;
    tick();
    jalr = 0;
    settle();
    n_cmp++; if (pc_out !== 32'h300 || misaligned_fault !== 1'b0) begin n_err++; $display("FAIL jalr_bit0 pc=%h fault=%0b want pc=00000300 fault=0", pc_out, misaligned_fault); end
    jalr = 1; jalr_address = 32'h302;
    tick();
    jalr = 0; imem_ready = 1;
    settle();
    n_cmp++; if (misaligned_fault !== 1'b1 || fault_addr !== 32'h302) begin n_err++; $display("FAIL jalr_fault fault=%0b addr=%h want fault=1 addr=00000302", misaligned_fault, fault_addr); end
    n_cmp++; if (pc_out !== 32'h300 || imem_req !== 1'b0) begin n_err++; $display("FAIL jalr_fault_hold pc=%h req=%0b want pc=00000300 req=0", pc_out, imem_req); end
    branch_jal = 1; branch_jump_address = 32'h400;
    tick();
    branch_jal = 0;
    settle();
    n_cmp++; if (misaligned_fault !== 1'b0 || fault_addr !== 32'h302) begin n_err++; $display("FAIL fault_pulse fault=%0b addr=%h want fault=0 addr=00000302", misaligned_fault, fault_addr); end
    n_cmp++; if (pc_out !== 32'h300 || imem_req !== 1'b0) begin n_err++; $display("FAIL fault_ignores_branch pc=%h req=%0b want pc=00000300 req=0", pc_out, imem_req); end
    trap = 1; trap_vector = 32'h80;
    tick();
    trap = 0;
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_err++; $display("FAIL fault_trap_exit req=%0b addr=%h want req=1 addr=00000080", imem_req, imem_addr); end
    tick();
    imem_valid = 1;
    settle();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'h80) begin n_err++; $display("FAIL fault_trap_fetch valid=%0b pc=%h want valid=1 pc=00000080", inst_valid, inst_pc); end
    tick();
    imem_valid = 0; imem_ready = 0;
    mret = 1; mepc = 32'h502;
    tick();
    mret = 0;
    settle();
    n_cmp++; if (misaligned_fault !== 1'b1 || fault_addr !== 32'h502) begin n_err++; $display("FAIL mret_fault fault=%0b addr=%h want fault=1 addr=00000502", misaligned_fault, fault_addr); end
  endtask

  task automatic test_wrap();
    do_reset();
    trap = 1; trap_vector = 32'hFFFF_FFFC;
    tick();
    trap = 0; imem_ready = 1;
    settle();
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr got=%h want=fffffffc", imem_addr); end
    tick();
    n_cmp++; if (pc_out !== 32'h0 || misaligned_fault !== 1'b0) begin n_err++; $display("FAIL wrap_pc pc=%h fault=%0b want pc=00000000 fault=0", pc_out, misaligned_fault); end
    imem_valid = 1;
    settle();
    n_cmp++; if (inst_valid !== 1'b1 || inst_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_resp valid=%0b pc=%h want valid=1 pc=fffffffc", inst_valid, inst_pc); end
    tick();
    imem_valid = 0;
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_next req=%0b addr=%h want req=1 addr=00000000", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    imem_ready = 1;
    tick();
    rst = 0; imem_valid = 1;
    settle();
    n_cmp++; if (imem_req !== 1'b0 || pc_out !== 32'h100) begin n_err++; $display("FAIL midrst_clear req=%0b pc=%h want req=0 pc=00000100", imem_req, pc_out); end
    n_cmp++; if (inst_valid !== 1'b0 || inst_pc !== 32'h100) begin n_err++; $display("FAIL midrst_resp valid=%0b pc=%h want valid=0 pc=00000100", inst_valid, inst_pc); end
    tick();
    rst = 1;
    settle();
    n_cmp++; if (inst_valid !== 1'b0 || imem_req !== 1'b0) begin n_err++; $display("FAIL midrst_drop valid=%0b req=%0b want valid=0 req=0", inst_valid, imem_req); end
    tick();
    imem_valid = 0;
    settle();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin n_err++; $display("FAIL midrst_restart req=%0b addr=%h want req=1 addr=00000100", imem_req, imem_addr); end
  endtask

  initial begin
    rst = 0;
    clear_inputs();
    test_reset();
    test_sequential();
    test_stall();
    test_branch_kill();
    test_redirect_on_accept();
    test_back_to_back();
    test_priority();
    test_jalr_fault();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
